// File: rtl/cpu_mc_pkg.sv
// Shared opcodes, instruction field layout and FSM states for the multi-cycle CPU.
// Pure definitions: no latency, no flow control.
package cpu_mc_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LW   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_BEQ  = 4'd9;
   localparam logic [3:0] OP_JAL  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RD_MSB = 11;
   localparam int RD_LSB = 9;
   localparam int RS_MSB = 8;
   localparam int RS_LSB = 6;
   localparam int RT_MSB = 5;
   localparam int RT_LSB = 3;
   localparam int IMM6_W = 6;
   localparam int IMM9_W = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_DONE
   } state_e;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op > OP_JAL) && (op != OP_HALT);
   endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/SLT, every other opcode adds (ADDI, LW/SW address).
// Zero latency, no flow control.
module cpu_mc_alu
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = a_i + b_i;
      case (op_i)
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SLT:  y_o = DATA_W'($signed(a_i) < $signed(b_i));
         default: y_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle CPU: IM/RF/DM + fetch/decode/exec/mem/wb FSM, 2..5 busy cycles per instruction.
// Program load is valid/ready (ready only in IDLE with IM space left); single-step stalls in FETCH.
module cpu_mc_core
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int IM_DEPTH = 64,
   parameter int DM_DEPTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_load_valid,
   output logic                        o_load_ready,
   input  logic [15:0]                 i_load_inst,
   input  logic                        i_start,
   input  logic                        i_step_en,
   input  logic                        i_step,
   input  logic                        i_dbg_sel,
   input  logic [7:0]                  i_dbg_addr,
   output logic [DATA_W-1:0]           o_dbg_data,
   output logic [$clog2(IM_DEPTH)-1:0] o_pc,
   output logic                        o_busy,
   output logic                        o_is_done,
   output logic                        o_illegal,
   output logic [31:0]                 o_cycle_cnt
);

   localparam int PW = $clog2(IM_DEPTH);
   localparam int AW = $clog2(DM_DEPTH);

   state_e            state_q, state_d;
   logic [PW-1:0]     pc_q, pc_d;
   logic [PW:0]       ptr_q, ptr_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              ill_q, ill_d;
   logic [31:0]       cnt_q, cnt_d;

   logic [15:0]       im_q [IM_DEPTH];
   logic [DATA_W-1:0] rf_q [8];
   logic [DATA_W-1:0] dm_q [DM_DEPTH];

   logic              im_we, rf_we, dm_we;
   logic [DATA_W-1:0] rf_wd;
   logic              load_rdy, stall, busy;

   logic [3:0]        f_op;
   logic [2:0]        f_rd, f_rs, f_rt;
   logic signed [IMM6_W-1:0] f_imm6;
   logic signed [IMM9_W-1:0] f_imm9;
   logic [DATA_W-1:0] rd_val, rs_val, rt_val, alu_b, alu_y;
   logic [PW:0]       pc_inc_w;
   logic [AW-1:0]     dm_addr, dbg_dm_addr;
   logic              dbg_unused;

   assign f_op   = ir_q[OP_MSB:OP_LSB];
   assign f_rd   = ir_q[RD_MSB:RD_LSB];
   assign f_rs   = ir_q[RS_MSB:RS_LSB];
   assign f_rt   = ir_q[RT_MSB:RT_LSB];
   assign f_imm6 = ir_q[IMM6_W-1:0];
   assign f_imm9 = ir_q[IMM9_W-1:0];

   assign rd_val = (f_rd == 3'd0) ? '0 : rf_q[f_rd];
   assign rs_val = (f_rs == 3'd0) ? '0 : rf_q[f_rs];
   assign rt_val = (f_rt == 3'd0) ? '0 : rf_q[f_rt];

   // R-type ops take rt; ADDI/LW/SW take the sign-extended immediate.
   assign alu_b    = (f_op <= OP_SLT) ? rt_val : DATA_W'(f_imm6);
   assign pc_inc_w = {1'b0, pc_q} + 1'b1;
   assign dm_addr  = AW'(res_q);

   cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i (f_op),
      .a_i  (rs_val),
      .b_i  (alu_b),
      .y_o  (alu_y)
   );

   assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)   || (state_q == S_WB);
   assign stall    = (state_q == S_FETCH) && i_step_en && !i_step;
   assign load_rdy = (state_q == S_IDLE) && (ptr_q != (PW+1)'(IM_DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      ir_d    = ir_q;
      res_d   = res_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      im_we   = 1'b0;
      rf_we   = 1'b0;
      dm_we   = 1'b0;
      rf_wd   = res_q;

      if (busy && !stall && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;

      if (i_load_valid && load_rdy) begin
         im_we = 1'b1;
         ptr_d = ptr_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               pc_d    = '0;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!stall) begin
               ir_d    = im_q[pc_q];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (f_op == OP_HALT) begin
               state_d = S_DONE;
            end else if (is_illegal(f_op)) begin
               ill_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (f_op)
               OP_BEQ: begin
                  pc_d    = (rd_val == rs_val) ? pc_q + PW'(f_imm6) : pc_inc_w[PW-1:0];
                  state_d = S_FETCH;
               end
               OP_JAL: begin
                  rf_we   = 1'b1;
                  rf_wd   = DATA_W'(pc_inc_w);
                  pc_d    = pc_q + PW'(f_imm9);
                  state_d = S_FETCH;
               end
               OP_LW, OP_SW: begin
                  res_d   = alu_y;
                  state_d = S_MEM;
               end
               default: begin
                  res_d   = alu_y;
                  state_d = S_WB;
               end
            endcase
         end
         S_MEM: begin
            if (f_op == OP_SW) begin
               dm_we   = 1'b1;
               pc_d    = pc_inc_w[PW-1:0];
               state_d = S_FETCH;
            end else begin
               res_d   = dm_q[dm_addr];
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_d    = pc_inc_w[PW-1:0];
            state_d = S_FETCH;
         end
         S_DONE: begin
            if (i_start) begin
               ill_d   = 1'b0;
               cnt_d   = '0;
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= '0;
         ptr_q <= '0;
         ir_q  <= '0;
         res_q <= '0;
         ill_q <= 1'b0;
         cnt_q <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
         for (int i = 0; i < DM_DEPTH; i++) dm_q[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         ir_q  <= ir_d;
         res_q <= res_d;
         ill_q <= ill_d;
         cnt_q <= cnt_d;
         if (rf_we && (f_rd != 3'd0)) rf_q[f_rd] <= rf_wd;
         if (dm_we) dm_q[dm_addr] <= rd_val;
      end
   end

   // IM survives reset so a loaded program can be rerun without reloading.
   always_ff @(posedge clk) begin
      if (im_we) im_q[ptr_q[PW-1:0]] <= i_load_inst;
   end

   assign dbg_dm_addr = AW'(i_dbg_addr);
   assign dbg_unused  = ^i_dbg_addr;
   assign o_dbg_data  = i_dbg_sel ? ((i_dbg_addr[2:0] == 3'd0) ? '0 : rf_q[i_dbg_addr[2:0]])
                                  : dm_q[dbg_dm_addr];

   assign o_load_ready = load_rdy;
   assign o_pc         = pc_q;
   assign o_busy       = busy;
   assign o_is_done    = (state_q == S_DONE);
   assign o_illegal    = ill_q;
   assign o_cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_mc_core.sv
// Bench for cpu_mc_core: directed programs plus random straight-line programs,
// compared against an instruction-level reference interpreter.
module tb_cpu_mc_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_load_valid, o_load_ready;
   logic [15:0] i_load_inst;
   logic        i_start, i_step_en, i_step, i_dbg_sel;
   logic [7:0]  i_dbg_addr, o_dbg_data;
   logic [5:0]  o_pc;
   logic        o_busy, o_is_done, o_illegal;
   logic [31:0] o_cycle_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_mc_core #(.DATA_W(8), .IM_DEPTH(64), .DM_DEPTH(64)) dut (
      .clk(clk), .rst(rst),
      .i_load_valid(i_load_valid), .o_load_ready(o_load_ready), .i_load_inst(i_load_inst),
      .i_start(i_start), .i_step_en(i_step_en), .i_step(i_step),
      .i_dbg_sel(i_dbg_sel), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
      .o_pc(o_pc), .o_busy(o_busy), .o_is_done(o_is_done),
      .o_illegal(o_illegal), .o_cycle_cnt(o_cycle_cnt)
   );

   // Reference machine state (architectural view only).
   logic [15:0] m_im [64];
   logic [7:0]  m_rf [8];
   logic [7:0]  m_dm [64];
   int          m_ptr, m_pc, m_cnt;
   logic        m_ill;
   logic [15:0] prog [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
      return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input int imm);
      return {op[3:0], rd[2:0], rs[2:0], imm[5:0]};
   endfunction

   function automatic logic [15:0] enc_j(input int op, input int rd, input int imm);
      return {op[3:0], rd[2:0], imm[8:0]};
   endfunction

   function automatic int reg_rd(input int i);
      return (i == 0) ? 0 : int'(m_rf[i]);
   endfunction

   function automatic void reg_wr(input int i, input int v);
      if (i != 0) m_rf[i] = 8'(v);
   endfunction

   // Interprets m_im from address 0 until HALT or an undefined opcode.
   task automatic ref_run();
      int pc, steps, op, rd, rs, rt, a, b, d, s6, s9, ad, sa, sb;
      logic [15:0] w;
      bit fin;
      pc = 0; steps = 0; fin = 0;
      m_cnt = 0; m_ill = 1'b0;
      while (!fin && steps < 4000) begin
         w  = m_im[pc];
         op = int'(w[15:12]); rd = int'(w[11:9]); rs = int'(w[8:6]); rt = int'(w[5:3]);
         s6 = int'(w[5:0]); if (s6 >= 32) s6 -= 64;
         s9 = int'(w[8:0]); if (s9 >= 256) s9 -= 512;
         a = reg_rd(rs); b = reg_rd(rt); d = reg_rd(rd);
         sa = (a >= 128) ? a - 256 : a;
         sb = (b >= 128) ? b - 256 : b;
         ad = ((a + s6) & 255) & 63;
         steps++;
         case (op)
            0: begin reg_wr(rd, a + b);  pc = (pc + 1) & 63; m_cnt += 4; end
            1: begin reg_wr(rd, a - b);  pc = (pc + 1) & 63; m_cnt += 4; end
            2: begin reg_wr(rd, a & b);  pc = (pc + 1) & 63; m_cnt += 4; end
            3: begin reg_wr(rd, a | b);  pc = (pc + 1) & 63; m_cnt += 4; end
            4: begin reg_wr(rd, a ^ b);  pc = (pc + 1) & 63; m_cnt += 4; end
            5: begin reg_wr(rd, (sa < sb) ? 1 : 0); pc = (pc + 1) & 63; m_cnt += 4; end
            6: begin reg_wr(rd, a + s6); pc = (pc + 1) & 63; m_cnt += 4; end
            7: begin reg_wr(rd, int'(m_dm[ad])); pc = (pc + 1) & 63; m_cnt += 5; end
            8: begin m_dm[ad] = 8'(d); pc = (pc + 1) & 63; m_cnt += 4; end
            9: begin pc = (d == a) ? ((pc + s6) & 63) : ((pc + 1) & 63); m_cnt += 3; end
            10: begin reg_wr(rd, pc + 1); pc = (pc + s9) & 63; m_cnt += 3; end
            15: begin fin = 1; m_cnt += 2; end
            default: begin fin = 1; m_ill = 1'b1; m_cnt += 2; end
         endcase
      end
      m_pc = pc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      for (int i = 0; i < 64; i++) m_dm[i] = '0;
      m_ptr = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_prog(input bit start_with_last);
      foreach (prog[i]) begin
         @(negedge clk);
         i_load_valid = 1'b1;
         i_load_inst  = prog[i];
         if (start_with_last && i == prog.size() - 1) i_start = 1'b1;
         check($sformatf("load_ready beat%0d", i), o_load_ready, m_ptr < 64);
         @(posedge clk);
         if (m_ptr < 64) begin
            m_im[m_ptr] = prog[i];
            m_ptr++;
         end
      end
      @(negedge clk);
      i_load_valid = 1'b0;
      i_start      = 1'b0;
   endtask

   task automatic start_pulse();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic dbg_rd(input logic sel, input int addr, output logic [7:0] v);
      i_dbg_sel  = sel;
      i_dbg_addr = addr[7:0];
      #1;
      v = o_dbg_data;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (o_is_done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done_timeout"}, o_is_done, 1);
   endtask

   task automatic compare_all(input string tag);
      logic [7:0] v;
      check({tag, " pc"}, o_pc, m_pc);
      check({tag, " illegal"}, o_illegal, m_ill);
      check({tag, " cycles"}, o_cycle_cnt, m_cnt);
      check({tag, " busy"}, o_busy, 0);
      for (int i = 0; i < 8; i++) begin
         dbg_rd(1'b1, i, v);
         check($sformatf("%s r%0d", tag, i), v, m_rf[i]);
      end
      for (int i = 0; i < 64; i++) begin
         dbg_rd(1'b0, i, v);
         check($sformatf("%s dm%0d", tag, i), v, m_dm[i]);
      end
   endtask

   task automatic run_and_check(input string tag, input bit do_start);
      ref_run();
      if (do_start) start_pulse();
      wait_done(tag);
      compare_all(tag);
   endtask

   initial begin
      logic [7:0] v;
      int op;
      rst = 1'b0; i_load_valid = 1'b0; i_load_inst = '0; i_start = 1'b0;
      i_step_en = 1'b0; i_step = 1'b0; i_dbg_sel = 1'b0; i_dbg_addr = '0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      for (int i = 0; i < 64; i++) begin m_dm[i] = '0; m_im[i] = 16'hF000; end
      m_ptr = 0;
      repeat (2) @(negedge clk);
      check("rst busy", o_busy, 0);
      check("rst done", o_is_done, 0);
      check("rst pc", o_pc, 0);
      check("rst illegal", o_illegal, 0);
      check("rst cycles", o_cycle_cnt, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst load_ready", o_load_ready, 1);

      // Straight-line ALU program
      do_reset();
      prog = {enc_i(6, 1, 0, 5), enc_i(6, 2, 0, -3), enc_r(0, 3, 1, 2), enc_j(15, 0, 0)};
      load_prog(1'b0);
      run_and_check("t1", 1'b1);
      dbg_rd(1'b1, 3, v); check("t1 r3 const", v, 8'h02);
      dbg_rd(1'b1, 2, v); check("t1 r2 const", v, 8'hFD);
      check("t1 cycles const", o_cycle_cnt, 14);
      check("t1 pc const", o_pc, 3);

      // Store with address wrap, load back
      do_reset();
      prog = {enc_i(6, 1, 0, 7), enc_i(6, 4, 0, -1), enc_i(8, 1, 4, 1), enc_i(7, 2, 0, 0), enc_j(15, 0, 0)};
      load_prog(1'b0);
      run_and_check("t2", 1'b1);
      dbg_rd(1'b0, 0, v); check("t2 dm0 const", v, 8'h07);
      dbg_rd(1'b1, 2, v); check("t2 r2 const", v, 8'h07);
      check("t2 cycles const", o_cycle_cnt, 19);

      // Loop with BEQ/JAL; start issued on the last load beat
      do_reset();
      prog = {enc_i(6, 1, 0, 3), enc_i(6, 1, 1, -1), enc_i(9, 1, 0, 2), enc_j(10, 0, -2), enc_j(15, 0, 0)};
      load_prog(1'b1);
      run_and_check("t3", 1'b0);
      dbg_rd(1'b1, 1, v); check("t3 r1 const", v, 8'h00);
      check("t3 pc const", o_pc, 4);
      check("t3 cycles const", o_cycle_cnt, 33);

      // Undefined opcode, then restart from DONE
      do_reset();
      prog = {16'hB000};
      load_prog(1'b0);
      run_and_check("t4", 1'b1);
      check("t4 illegal const", o_illegal, 1);
      check("t4 cycles const", o_cycle_cnt, 2);
      start_pulse();
      check("t4 restart illegal", o_illegal, 0);
      check("t4 restart busy", o_busy, 1);
      run_and_check("t4b", 1'b0);

      // Single-step
      do_reset();
      prog = {enc_i(6, 1, 0, 5), enc_i(6, 2, 0, 6), enc_j(15, 0, 0)};
      load_prog(1'b0);
      i_step_en = 1'b1;
      start_pulse();
      repeat (10) @(negedge clk);
      check("t5 stall busy", o_busy, 1);
      check("t5 stall pc", o_pc, 0);
      check("t5 stall cycles", o_cycle_cnt, 0);
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
      repeat (8) @(negedge clk);
      check("t5 step pc", o_pc, 1);
      check("t5 step cycles", o_cycle_cnt, 4);
      dbg_rd(1'b1, 1, v); check("t5 step r1", v, 8'd5);
      dbg_rd(1'b1, 2, v); check("t5 step r2", v, 8'd0);
      i_step_en = 1'b0;
      run_and_check("t5", 1'b0);

      // Load flood: the 65th word must be refused and IM[0] kept
      do_reset();
      prog = {16'hF000};
      for (int i = 1; i < 64; i++) prog.push_back(16'($urandom));
      prog.push_back(16'hB000);
      load_prog(1'b0);
      check("t6 ready after flood", o_load_ready, 0);
      run_and_check("t6", 1'b1);

      // Asynchronous reset mid-run
      do_reset();
      prog = {enc_i(6, 1, 0, 5), enc_i(6, 2, 0, -3), enc_r(0, 3, 1, 2), enc_j(15, 0, 0)};
      load_prog(1'b0);
      start_pulse();
      repeat (8) @(negedge clk);
      check("t7 pre busy", o_busy, 1);
      check("t7 pre pc", o_pc, 2);
      dbg_rd(1'b1, 1, v); check("t7 pre r1", v, 8'd5);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t7 rst busy", o_busy, 0);
      check("t7 rst pc", o_pc, 0);
      dbg_rd(1'b1, 1, v); check("t7 rst r1", v, 8'd0);
      @(negedge clk);
      rst = 1'b1;

      // Random straight-line programs, each also rerun from DONE with retained state
      for (int t = 0; t < 4; t++) begin
         do_reset();
         prog.delete();
         for (int k = 0; k < 14; k++) begin
            op = $urandom_range(0, 8);
            if (op <= 5) prog.push_back(enc_r(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            else         prog.push_back(enc_i(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63)));
         end
         prog.push_back(enc_j(15, 0, 0));
         load_prog(1'b0);
         run_and_check($sformatf("rnd%0d", t), 1'b1);
         run_and_check($sformatf("rnd%0d_rerun", t), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
